// File: rtl/conv_pkg.sv
// Shared types and helpers for the 2-D convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, LDF, PIX, WR, DONE} state_t;

  // Width used for the generic saturation helper; must cover any ACC_W in use.
  localparam int MAXW = 128;

  function automatic int calc_oh(input int img_h, input int k);
    return img_h - k + 1;
  endfunction

  function automatic int calc_ow(input int img_w, input int k);
    return img_w - k + 1;
  endfunction

  function automatic int calc_ntap(input int k);
    return k * k;
  endfunction

  function automatic int calc_acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

  // Clamp a sign-extended accumulator into the signed dw-bit range.
  function automatic logic signed [MAXW-1:0] sat_dw(input logic signed [MAXW-1:0] acc,
                                                   input int dw);
    logic signed [MAXW-1:0] hi, lo;
    hi = ({{(MAXW-1){1'b0}}, 1'b1} << (dw - 1)) - {{(MAXW-1){1'b0}}, 1'b1};
    lo = ~hi;
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate; products are sign-extended into the wide accumulator.
module conv_mac #(
  parameter int DW    = 32,
  parameter int ACC_W = 68
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [DW-1:0]           a,
  input  logic [DW-1:0]           b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0] w_ax, w_bx, w_prod;
  logic signed [ACC_W-1:0] r_acc;

  assign w_ax   = (2*DW)'($signed(a));
  assign w_bx   = (2*DW)'($signed(b));
  assign w_prod = w_ax * w_bx;
  assign acc    = r_acc;

  // Clear takes priority over accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     r_acc <= '0;
    else if (clr) r_acc <= '0;
    else if (en)  r_acc <= r_acc + ACC_W'(w_prod);
  end

endmodule

// File: rtl/conv2d_engine.sv
// Valid KxK convolution over a row-major image in single-port memory,
// with saturation and optional ReLU on each written pixel.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 7,
  parameter int K     = 3,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          relu_en,
  input  logic [AW-1:0] x,
  input  logic [AW-1:0] y,
  input  logic [AW-1:0] z,
  input  logic [DW-1:0] mem_out,
  output logic [AW-1:0] mem_index,
  output logic [DW-1:0] mem_in,
  output logic          mem_wr,
  output logic          busy,
  output logic          done
);

  localparam int OH    = calc_oh(IMG_H, K);
  localparam int OW    = calc_ow(IMG_W, K);
  localparam int NTAP  = calc_ntap(K);
  localparam int ACC_W = calc_acc_w(DW, K);
  localparam int TW    = $clog2(NTAP + 1);
  localparam int KW    = $clog2(K + 1);
  localparam int RW    = $clog2(OH + 1);
  localparam int CW    = $clog2(OW + 1);

  state_t r_state, w_next;

  logic [AW-1:0] r_x, r_y, r_z;
  logic          r_relu;
  logic [TW-1:0] r_tap;
  logic [KW-1:0] r_i, r_j;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [DW-1:0] r_filt [NTAP];

  logic                    w_last_tap, w_last_pix, w_clr, w_en;
  logic [TW-1:0]           w_fidx;
  logic [DW-1:0]           w_fa, w_sat, w_res;
  logic [AW-1:0]           w_pix_addr, w_wr_addr;
  logic signed [ACC_W-1:0] w_acc;

  assign w_last_tap = (r_tap == TW'(NTAP));
  assign w_last_pix = (r_row == RW'(OH - 1)) && (r_col == CW'(OW - 1));
  // Tap t's data returns one cycle after issue, so it pairs with filt[t-1].
  assign w_fidx     = r_tap - TW'(1);
  assign w_fa       = (r_tap != '0) ? r_filt[w_fidx] : '0;
  assign w_clr      = (r_state == PIX) && (r_tap == '0);
  assign w_en       = (r_state == PIX) && (r_tap != '0);

  assign w_pix_addr = r_y + AW'((32'(r_row) + 32'(r_i)) * 32'(IMG_W) + 32'(r_col) + 32'(r_j));
  assign w_wr_addr  = r_z + AW'(32'(r_row) * 32'(OW) + 32'(r_col));
  assign w_sat      = DW'(sat_dw(MAXW'(w_acc), DW));
  assign w_res      = (r_relu && w_sat[DW-1]) ? '0 : w_sat;

  conv_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_en),
    .a   (w_fa),
    .b   (mem_out),
    .acc (w_acc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state and memory-port decode; the port is idle unless an access is issued.
  always_comb begin
    w_next    = r_state;
    mem_index = '0;
    mem_in    = '0;
    mem_wr    = 1'b0;
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    case (r_state)
      IDLE: if (start) w_next = LDF;
      LDF: begin
        if (w_last_tap) w_next = PIX;
        else            mem_index = r_x + AW'(r_tap);
      end
      PIX: begin
        if (w_last_tap) w_next = WR;
        else            mem_index = w_pix_addr;
      end
      WR: begin
        mem_wr    = 1'b1;
        mem_index = w_wr_addr;
        mem_in    = w_res;
        w_next    = w_last_pix ? DONE : PIX;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Job parameters, tap/pixel counters and filter capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_relu <= 1'b0;
      r_tap  <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_row  <= '0;
      r_col  <= '0;
      for (int t = 0; t < NTAP; t++) r_filt[t] <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_x    <= x;
          r_y    <= y;
          r_z    <= z;
          r_relu <= relu_en;
          r_tap  <= '0;
          r_i    <= '0;
          r_j    <= '0;
          r_row  <= '0;
          r_col  <= '0;
        end
        LDF: begin
          if (r_tap != '0) r_filt[w_fidx] <= mem_out;
          r_tap <= w_last_tap ? '0 : r_tap + TW'(1);
        end
        PIX: begin
          if (w_last_tap) begin
            r_tap <= '0;
            r_i   <= '0;
            r_j   <= '0;
          end else begin
            r_tap <= r_tap + TW'(1);
            if (r_j == KW'(K - 1)) begin
              r_j <= '0;
              r_i <= r_i + KW'(1);
            end else begin
              r_j <= r_j + KW'(1);
            end
          end
        end
        WR: begin
          if (r_col == CW'(OW - 1)) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_engine.sv
// Directed bench for conv2d_engine with a 1-cycle-latency memory model.
module tb_conv2d_engine;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam logic [DW-1:0] SENT = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          relu_en = 1'b0;
  logic [AW-1:0] x = '0, y = '0, z = '0;
  logic [DW-1:0] mem_out;
  logic [AW-1:0] mem_index;
  logic [DW-1:0] mem_in;
  logic          mem_wr, busy, done;

  logic [DW-1:0] mem [128];
  logic [DW-1:0] init_mem [128];
  logic          load = 1'b0;
  int            wr_total = 0;
  int            wr_hits [128] = '{default: 0};
  int            done_cnt = 0;

  int errs = 0;
  int checks = 0;

  conv2d_engine dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .x(x), .y(y), .z(z), .mem_out(mem_out),
    .mem_index(mem_index), .mem_in(mem_in), .mem_wr(mem_wr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, write on mem_wr, bulk load from init_mem.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_mem[i];
    end else if (mem_wr) begin
      mem[mem_index]     <= mem_in;
      wr_total           <= wr_total + 1;
      wr_hits[mem_index] <= wr_hits[mem_index] + 1;
    end
    mem_out <= mem[mem_index];
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic load_mem;
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic set_const(input logic [DW-1:0] fv, input logic [DW-1:0] iv);
    for (int i = 0; i < 128; i++) init_mem[i] = SENT;
    for (int t = 0; t < 9; t++) init_mem[t] = fv;
    for (int n = 0; n < 36; n++) init_mem[9+n] = iv;
    load_mem();
  endtask

  task automatic set_identity;
    for (int i = 0; i < 128; i++) init_mem[i] = SENT;
    for (int t = 0; t < 9; t++) init_mem[t] = (t == 4) ? 32'd1 : 32'd0;
    for (int n = 0; n < 36; n++) init_mem[9+n] = n;
    load_mem();
  endtask

  task automatic start_job(input logic [AW-1:0] fx, input logic [AW-1:0] fy,
                           input logic [AW-1:0] fz, input logic rl);
    @(negedge clk);
    x = fx; y = fy; z = fz; relu_en = rl; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycles from the start-sampling edge until done is seen; 1000 means timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 1000) begin
      @(negedge clk);
      if (done) break;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) start = ~start;
    end
    checks++; if (mem_wr !== 1'b0) begin errs++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (mem_index !== '0) begin errs++; $display("FAIL reset_index: got %0d want 0", mem_index); end
    start = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    checks++; if (mem_wr !== 1'b0) begin errs++; $display("FAIL post_reset_wr: got %b want 0", mem_wr); end
    checks++; if (mem_index !== '0) begin errs++; $display("FAIL post_reset_index: got %0d want 0", mem_index); end
  endtask

  task automatic test_identity;
    int lat, d0, w0, ev;
    set_identity();
    d0 = done_cnt; w0 = wr_total;
    start_job(7'd0, 7'd9, 7'd45, 1'b0);
    wait_done(lat);
    checks++; if (lat != 186) begin errs++; $display("FAIL ident_latency: got %0d want 186", lat); end
    repeat (2) @(negedge clk);
    checks++; if (mem[45] !== 32'd7) begin errs++; $display("FAIL ident_mem45: got %0h want 7", mem[45]); end
    checks++; if (mem[60] !== 32'd28) begin errs++; $display("FAIL ident_mem60: got %0h want 1c", mem[60]); end
    for (int k = 0; k < 16; k++) begin
      ev = ((k / 4) + 1) * 6 + (k % 4) + 1;
      checks++;
      if (mem[45+k] !== DW'(ev)) begin
        errs++; $display("FAIL ident_out%0d: got %0h want %0h", k, mem[45+k], ev);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL ident_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (wr_total - w0 != 16) begin errs++; $display("FAIL ident_writes: got %0d want 16", wr_total - w0); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL ident_idle_busy: got %b want 0", busy); end
  endtask

  // Table: filter value, image value, relu, expected output.
  task automatic test_relu_sat;
    logic [DW-1:0] tf [5] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    logic [DW-1:0] ti [5] = '{32'd1, 32'd1, 32'd1, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic          tr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] te [5] = '{32'd9, 32'hFFFFFFF7, 32'd0, 32'h7FFFFFFF, 32'h80000000};
    int lat, w0;
    for (int v = 0; v < 5; v++) begin
      set_const(tf[v], ti[v]);
      w0 = wr_total;
      start_job(7'd0, 7'd9, 7'd45, tr[v]);
      wait_done(lat);
      repeat (2) @(negedge clk);
      checks++; if (lat != 186) begin errs++; $display("FAIL const%0d_latency: got %0d want 186", v, lat); end
      checks++; if (wr_total - w0 != 16) begin errs++; $display("FAIL const%0d_writes: got %0d want 16", v, wr_total - w0); end
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (mem[45+k] !== te[v]) begin
          errs++; $display("FAIL const%0d_out%0d: got %0h want %0h", v, k, mem[45+k], te[v]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, w0, w1, ev;
    // Second start mid-job must be ignored.
    set_identity();
    w0 = wr_total;
    start_job(7'd0, 7'd9, 7'd45, 1'b0);
    repeat (19) @(negedge clk);
    x = 7'd1; y = 7'd2; z = 7'd70; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(lat);
    repeat (2) @(negedge clk);
    checks++; if (lat >= 1000) begin errs++; $display("FAIL restart_done_timeout: got %0d want <1000", lat); end
    checks++; if (wr_total - w0 != 16) begin errs++; $display("FAIL restart_writes: got %0d want 16", wr_total - w0); end
    for (int k = 0; k < 16; k++) begin
      ev = ((k / 4) + 1) * 6 + (k % 4) + 1;
      checks++;
      if (mem[45+k] !== DW'(ev)) begin
        errs++; $display("FAIL restart_out%0d: got %0h want %0h", k, mem[45+k], ev);
      end
    end
    // Abort with reset mid-job.
    set_identity();
    start_job(7'd0, 7'd9, 7'd45, 1'b0);
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0) begin errs++; $display("FAIL abort_wr: got %b want 0", mem_wr); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b want 0", busy); end
    w1 = wr_total;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (250) @(negedge clk);
    checks++; if (wr_total != w1) begin errs++; $display("FAIL abort_writes: got %0d want %0d", wr_total, w1); end
    checks++; if (mem[60] !== SENT) begin errs++; $display("FAIL abort_mem60: got %0h want %0h", mem[60], SENT); end
    // Restart after abort.
    start_job(7'd0, 7'd9, 7'd45, 1'b0);
    wait_done(lat);
    repeat (2) @(negedge clk);
    checks++; if (lat != 186) begin errs++; $display("FAIL rerun_latency: got %0d want 186", lat); end
    for (int k = 0; k < 16; k++) begin
      ev = ((k / 4) + 1) * 6 + (k % 4) + 1;
      checks++;
      if (mem[45+k] !== DW'(ev)) begin
        errs++; $display("FAIL rerun_out%0d: got %0h want %0h", k, mem[45+k], ev);
      end
    end
  endtask

  task automatic test_wrap;
    int lat, d0, w0, ev, a;
    int h0 [128];
    set_identity();
    h0 = wr_hits;
    d0 = done_cnt; w0 = wr_total;
    start_job(7'd0, 7'd9, 7'd120, 1'b0);
    wait_done(lat);
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (wr_total - w0 != 16) begin errs++; $display("FAIL wrap_writes: got %0d want 16", wr_total - w0); end
    for (int k = 0; k < 16; k++) begin
      ev = ((k / 4) + 1) * 6 + (k % 4) + 1;
      a  = (120 + k) % 128;
      checks++;
      if (mem[a] !== DW'(ev)) begin
        errs++; $display("FAIL wrap_out%0d: got %0h want %0h at %0d", k, mem[a], ev, a);
      end
      checks++;
      if (wr_hits[a] - h0[a] != 1) begin
        errs++; $display("FAIL wrap_hits%0d: got %0d want 1", a, wr_hits[a] - h0[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_relu_sat();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
